// File: rtl/scene_bank_loader.sv
// Double-buffered polygon scene store: vertex beats build the back bank,
// and a frame-start pulse in READY makes it the front bank seen by the draw units.
module scene_bank_loader #(
    parameter int MAX_NUM_VERTICES       = 8,
    parameter int MAX_POLYGONS_ON_SCREEN = 4
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic                                          frame_start_in,
    input  logic                                          vertex_valid_in,
    output logic                                          vertex_ready_out,
    input  logic signed [31:0]                            vertex_x_in,
    input  logic signed [31:0]                            vertex_y_in,
    input  logic                                          vertex_last_in,
    input  logic                                          scene_last_in,
    output logic signed [31:0]                            xs_out [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES],
    output logic signed [31:0]                            ys_out [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]         num_sides_out [MAX_POLYGONS_ON_SCREEN],
    output logic [$clog2(MAX_POLYGONS_ON_SCREEN+1)-1:0]   polygons_on_screen_out,
    output logic                                          swap_out,
    output logic                                          overflow_out
);

    localparam int VW  = $clog2(MAX_NUM_VERTICES + 1);
    localparam int PW  = $clog2(MAX_POLYGONS_ON_SCREEN + 1);
    localparam int VSW = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;
    localparam int PSW = (MAX_POLYGONS_ON_SCREEN > 1) ? $clog2(MAX_POLYGONS_ON_SCREEN) : 1;

    localparam logic [VW-1:0] VMAX     = VW'(MAX_NUM_VERTICES);
    localparam logic [PW-1:0] PMAX     = PW'(MAX_POLYGONS_ON_SCREEN);
    localparam logic [VW:0]   MIN_SIDE = (VW+1)'(3);

    typedef enum logic [0:0] {
        S_LOAD  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic          bank_sel_q, bank_sel_d;
    logic [PW-1:0] poly_idx_q, poly_idx_d;
    logic [VW-1:0] vert_idx_q, vert_idx_d;
    logic          swap_q, swap_d;
    logic          overflow_q, overflow_d;

    logic [VW-1:0]      num_sides_q [2][MAX_POLYGONS_ON_SCREEN];
    logic [VW-1:0]      num_sides_d [2][MAX_POLYGONS_ON_SCREEN];
    logic [PW-1:0]      poly_count_q [2];
    logic [PW-1:0]      poly_count_d [2];
    logic signed [31:0] xs_q [2][MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES];
    logic signed [31:0] xs_d [2][MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES];
    logic signed [31:0] ys_q [2][MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES];
    logic signed [31:0] ys_d [2][MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES];

    logic           accept;
    logic           back_sel;
    logic           poly_full;
    logic           vert_full;
    logic           store;
    logic           commit;
    logic           do_swap;
    logic [VW:0]    vert_cnt;
    logic [VW-1:0]  sides_cnt;
    logic [PSW-1:0] poly_sel;
    logic [VSW-1:0] vert_sel;

    // ---------------- state register ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (accept && vertex_last_in && scene_last_in) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (frame_start_in) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        vertex_ready_out = (state_q == S_LOAD);
    end

    // ---------------- beat classification ----------------
    always_comb begin
        accept    = vertex_valid_in && vertex_ready_out;
        back_sel  = ~bank_sel_q;
        poly_full = (poly_idx_q >= PMAX);
        vert_full = (vert_idx_q >= VMAX);
        vert_cnt  = {1'b0, vert_idx_q} + (VW+1)'(1);
        sides_cnt = (vert_cnt > {1'b0, VMAX}) ? VMAX : vert_cnt[VW-1:0];
        poly_sel  = poly_idx_q[PSW-1:0];
        vert_sel  = vert_idx_q[VSW-1:0];
        store     = accept && !poly_full && !vert_full;
        commit    = accept && vertex_last_in && !poly_full && (vert_cnt >= MIN_SIDE);
        do_swap   = (state_q == S_READY) && frame_start_in;
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        bank_sel_d   = bank_sel_q;
        poly_idx_d   = poly_idx_q;
        vert_idx_d   = vert_idx_q;
        swap_d       = do_swap;
        overflow_d   = overflow_q;
        num_sides_d  = num_sides_q;
        poly_count_d = poly_count_q;
        xs_d         = xs_q;
        ys_d         = ys_q;

        if (store) begin
            xs_d[back_sel][poly_sel][vert_sel] = vertex_x_in;
            ys_d[back_sel][poly_sel][vert_sel] = vertex_y_in;
        end

        if (accept) begin
            if (vert_full || poly_full) begin
                overflow_d = 1'b1;
            end
            // A closing beat always restarts the vertex index, whether the slot
            // was committed, discarded as degenerate, or dropped for lack of room.
            if (vertex_last_in) begin
                vert_idx_d = '0;
            end else if (!vert_full) begin
                vert_idx_d = vert_idx_q + VW'(1);
            end
            if (commit) begin
                num_sides_d[back_sel][poly_sel] = sides_cnt;
                poly_count_d[back_sel]          = poly_idx_q + PW'(1);
                poly_idx_d                      = poly_idx_q + PW'(1);
            end
        end

        // The outgoing front bank becomes the new back bank and starts empty.
        if (do_swap) begin
            bank_sel_d               = ~bank_sel_q;
            poly_count_d[bank_sel_q] = '0;
            poly_idx_d               = '0;
            vert_idx_d               = '0;
            overflow_d               = 1'b0;
        end
    end

    // ---------------- control and count registers ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bank_sel_q   <= 1'b0;
            poly_idx_q   <= '0;
            vert_idx_q   <= '0;
            swap_q       <= 1'b0;
            overflow_q   <= 1'b0;
            num_sides_q  <= '{default: '{default: '0}};
            poly_count_q <= '{default: '0};
        end else begin
            bank_sel_q   <= bank_sel_d;
            poly_idx_q   <= poly_idx_d;
            vert_idx_q   <= vert_idx_d;
            swap_q       <= swap_d;
            overflow_q   <= overflow_d;
            num_sides_q  <= num_sides_d;
            poly_count_q <= poly_count_d;
        end
    end

    // Coordinates carry no reset; consumers gate on the polygon count.
    always_ff @(posedge clk_in) begin
        xs_q <= xs_d;
        ys_q <= ys_d;
    end

    // ---------------- front-bank outputs ----------------
    always_comb begin
        xs_out                 = xs_q[bank_sel_q];
        ys_out                 = ys_q[bank_sel_q];
        num_sides_out          = num_sides_q[bank_sel_q];
        polygons_on_screen_out = poly_count_q[bank_sel_q];
        swap_out               = swap_q;
        overflow_out           = overflow_q;
    end

endmodule

// File: tb/tb_scene_bank_loader.sv
// Directed self-checking bench for scene_bank_loader: scene loading, swapping,
// overflow handling, degenerate polygons and reset behaviour.
module tb_scene_bank_loader;

    logic                clk_in;
    logic                rst_in;
    logic                frame_start_in;
    logic                vertex_valid_in;
    logic                vertex_ready_out;
    logic signed [31:0]  vertex_x_in;
    logic signed [31:0]  vertex_y_in;
    logic                vertex_last_in;
    logic                scene_last_in;
    logic signed [31:0]  xs_out [4][8];
    logic signed [31:0]  ys_out [4][8];
    logic [3:0]          num_sides_out [4];
    logic [2:0]          polygons_on_screen_out;
    logic                swap_out;
    logic                overflow_out;

    int checks;
    int failures;

    scene_bank_loader #(
        .MAX_NUM_VERTICES(8),
        .MAX_POLYGONS_ON_SCREEN(4)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .frame_start_in(frame_start_in),
        .vertex_valid_in(vertex_valid_in),
        .vertex_ready_out(vertex_ready_out),
        .vertex_x_in(vertex_x_in),
        .vertex_y_in(vertex_y_in),
        .vertex_last_in(vertex_last_in),
        .scene_last_in(scene_last_in),
        .xs_out(xs_out),
        .ys_out(ys_out),
        .num_sides_out(num_sides_out),
        .polygons_on_screen_out(polygons_on_screen_out),
        .swap_out(swap_out),
        .overflow_out(overflow_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_beat(input int x, input int y, input logic last,
                             input logic sl, input logic fs);
        vertex_valid_in = 1'b1;
        vertex_x_in     = x;
        vertex_y_in     = y;
        vertex_last_in  = last;
        scene_last_in   = sl;
        frame_start_in  = fs;
        tick();
        vertex_valid_in = 1'b0;
        vertex_last_in  = 1'b0;
        scene_last_in   = 1'b0;
        frame_start_in  = 1'b0;
    endtask

    // n beats with x = x0+i, y = x0+100+i; last on the final beat.
    task automatic send_poly(input int n, input int x0, input logic sl, input logic fs);
        for (int i = 0; i < n; i++) begin
            send_beat(x0 + i, x0 + 100 + i, (i == n - 1), sl && (i == n - 1), fs && (i == n - 1));
        end
    endtask

    task automatic pulse_frame();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        checks++; if (vertex_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0d exp=1", vertex_ready_out); end
        checks++; if (polygons_on_screen_out !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", polygons_on_screen_out); end
        checks++; if (swap_out !== 1'b0) begin failures++; $display("FAIL reset_swap got=%0d exp=0", swap_out); end
        checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0d exp=0", overflow_out); end
        checks++; if (num_sides_out[0] !== 4'd0) begin failures++; $display("FAIL reset_sides0 got=%0d exp=0", num_sides_out[0]); end
    endtask

    task automatic test_basic();
        send_beat(100, 100, 1'b0, 1'b0, 1'b0);
        send_beat(200, 100, 1'b0, 1'b0, 1'b0);
        send_beat(200, 200, 1'b0, 1'b0, 1'b0);
        checks++; if (vertex_ready_out !== 1'b1) begin failures++; $display("FAIL basic_ready_load got=%0d exp=1", vertex_ready_out); end
        send_beat(100, 200, 1'b1, 1'b1, 1'b0);
        checks++; if (vertex_ready_out !== 1'b0) begin failures++; $display("FAIL basic_ready_after_close got=%0d exp=0", vertex_ready_out); end
        checks++; if (polygons_on_screen_out !== 3'd0) begin failures++; $display("FAIL basic_count_preswap got=%0d exp=0", polygons_on_screen_out); end
        pulse_frame();
        checks++; if (swap_out !== 1'b1) begin failures++; $display("FAIL basic_swap got=%0d exp=1", swap_out); end
        checks++; if (polygons_on_screen_out !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", polygons_on_screen_out); end
        checks++; if (num_sides_out[0] !== 4'd4) begin failures++; $display("FAIL basic_sides0 got=%0d exp=4", num_sides_out[0]); end
        checks++; if (xs_out[0][2] !== 32'sd200) begin failures++; $display("FAIL basic_x02 got=%0d exp=200", xs_out[0][2]); end
        checks++; if (ys_out[0][3] !== 32'sd200) begin failures++; $display("FAIL basic_y03 got=%0d exp=200", ys_out[0][3]); end
        checks++; if (vertex_ready_out !== 1'b1) begin failures++; $display("FAIL basic_ready_after_swap got=%0d exp=1", vertex_ready_out); end
        tick();
        checks++; if (swap_out !== 1'b0) begin failures++; $display("FAIL basic_swap_pulse_width got=%0d exp=0", swap_out); end
    endtask

    task automatic test_three_polys();
        send_poly(4, 10, 1'b0, 1'b0);
        send_poly(3, 20, 1'b0, 1'b0);
        send_poly(5, -30, 1'b1, 1'b0);
        pulse_frame();
        checks++; if (polygons_on_screen_out !== 3'd3) begin failures++; $display("FAIL three_count got=%0d exp=3", polygons_on_screen_out); end
        checks++; if (num_sides_out[0] !== 4'd4) begin failures++; $display("FAIL three_sides0 got=%0d exp=4", num_sides_out[0]); end
        checks++; if (num_sides_out[1] !== 4'd3) begin failures++; $display("FAIL three_sides1 got=%0d exp=3", num_sides_out[1]); end
        checks++; if (num_sides_out[2] !== 4'd5) begin failures++; $display("FAIL three_sides2 got=%0d exp=5", num_sides_out[2]); end
        checks++; if (xs_out[2][4] !== -32'sd26) begin failures++; $display("FAIL three_x24 got=%0d exp=-26", xs_out[2][4]); end
        checks++; if (ys_out[1][2] !== 32'sd122) begin failures++; $display("FAIL three_y12 got=%0d exp=122", ys_out[1][2]); end
        send_poly(3, 500, 1'b1, 1'b0);
        tick();
        tick();
        checks++; if (polygons_on_screen_out !== 3'd3) begin failures++; $display("FAIL three_hold_count got=%0d exp=3", polygons_on_screen_out); end
        checks++; if (swap_out !== 1'b0) begin failures++; $display("FAIL three_hold_swap got=%0d exp=0", swap_out); end
        checks++; if (vertex_ready_out !== 1'b0) begin failures++; $display("FAIL three_hold_ready got=%0d exp=0", vertex_ready_out); end
        pulse_frame();
        checks++; if (polygons_on_screen_out !== 3'd1) begin failures++; $display("FAIL three_next_count got=%0d exp=1", polygons_on_screen_out); end
        checks++; if (xs_out[0][1] !== 32'sd501) begin failures++; $display("FAIL three_next_x01 got=%0d exp=501", xs_out[0][1]); end
    endtask

    task automatic test_vertex_overflow();
        for (int i = 0; i < 9; i++) begin
            send_beat(10 * i + 1, 7, 1'b0, 1'b0, 1'b0);
            checks++; if (vertex_ready_out !== 1'b1) begin failures++; $display("FAIL vov_ready beat=%0d got=%0d exp=1", i, vertex_ready_out); end
        end
        checks++; if (overflow_out !== 1'b1) begin failures++; $display("FAIL vov_overflow_early got=%0d exp=1", overflow_out); end
        send_beat(91, 7, 1'b1, 1'b1, 1'b0);
        checks++; if (overflow_out !== 1'b1) begin failures++; $display("FAIL vov_overflow got=%0d exp=1", overflow_out); end
        pulse_frame();
        checks++; if (num_sides_out[0] !== 4'd8) begin failures++; $display("FAIL vov_sides0 got=%0d exp=8", num_sides_out[0]); end
        checks++; if (polygons_on_screen_out !== 3'd1) begin failures++; $display("FAIL vov_count got=%0d exp=1", polygons_on_screen_out); end
        checks++; if (xs_out[0][7] !== 32'sd71) begin failures++; $display("FAIL vov_x07 got=%0d exp=71", xs_out[0][7]); end
        checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL vov_overflow_cleared got=%0d exp=0", overflow_out); end
    endtask

    task automatic test_poly_overflow();
        for (int t = 0; t < 6; t++) begin
            send_poly(3, 1000 + 10 * t, (t == 5), 1'b0);
        end
        checks++; if (vertex_ready_out !== 1'b0) begin failures++; $display("FAIL pov_ready got=%0d exp=0", vertex_ready_out); end
        checks++; if (overflow_out !== 1'b1) begin failures++; $display("FAIL pov_overflow got=%0d exp=1", overflow_out); end
        pulse_frame();
        checks++; if (polygons_on_screen_out !== 3'd4) begin failures++; $display("FAIL pov_count got=%0d exp=4", polygons_on_screen_out); end
        checks++; if (xs_out[3][0] !== 32'sd1030) begin failures++; $display("FAIL pov_x30 got=%0d exp=1030", xs_out[3][0]); end
        checks++; if (num_sides_out[3] !== 4'd3) begin failures++; $display("FAIL pov_sides3 got=%0d exp=3", num_sides_out[3]); end
    endtask

    task automatic test_degenerate();
        send_poly(3, 5, 1'b0, 1'b0);
        send_poly(2, 50, 1'b0, 1'b0);
        send_poly(3, 70, 1'b1, 1'b0);
        pulse_frame();
        checks++; if (polygons_on_screen_out !== 3'd2) begin failures++; $display("FAIL degen_count got=%0d exp=2", polygons_on_screen_out); end
        checks++; if (num_sides_out[1] !== 4'd3) begin failures++; $display("FAIL degen_sides1 got=%0d exp=3", num_sides_out[1]); end
        checks++; if (xs_out[1][0] !== 32'sd70) begin failures++; $display("FAIL degen_x10 got=%0d exp=70", xs_out[1][0]); end
        checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL degen_overflow got=%0d exp=0", overflow_out); end
    endtask

    task automatic test_back_to_back_frame();
        send_poly(3, 300, 1'b1, 1'b1);
        checks++; if (swap_out !== 1'b0) begin failures++; $display("FAIL coinc_swap got=%0d exp=0", swap_out); end
        checks++; if (polygons_on_screen_out !== 3'd2) begin failures++; $display("FAIL coinc_count got=%0d exp=2", polygons_on_screen_out); end
        checks++; if (vertex_ready_out !== 1'b0) begin failures++; $display("FAIL coinc_ready got=%0d exp=0", vertex_ready_out); end
        pulse_frame();
        checks++; if (swap_out !== 1'b1) begin failures++; $display("FAIL coinc_next_swap got=%0d exp=1", swap_out); end
        checks++; if (polygons_on_screen_out !== 3'd1) begin failures++; $display("FAIL coinc_next_count got=%0d exp=1", polygons_on_screen_out); end
    endtask

    task automatic test_empty_scene();
        send_poly(2, 900, 1'b1, 1'b0);
        checks++; if (vertex_ready_out !== 1'b0) begin failures++; $display("FAIL empty_ready got=%0d exp=0", vertex_ready_out); end
        pulse_frame();
        checks++; if (swap_out !== 1'b1) begin failures++; $display("FAIL empty_swap got=%0d exp=1", swap_out); end
        checks++; if (polygons_on_screen_out !== 3'd0) begin failures++; $display("FAIL empty_count got=%0d exp=0", polygons_on_screen_out); end
    endtask

    task automatic test_reset_mid();
        send_poly(3, 40, 1'b1, 1'b0);
        pulse_frame();
        checks++; if (polygons_on_screen_out !== 3'd1) begin failures++; $display("FAIL rmid_pre_count got=%0d exp=1", polygons_on_screen_out); end
        send_beat(600, 1, 1'b0, 1'b0, 1'b0);
        send_beat(601, 1, 1'b0, 1'b0, 1'b0);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        checks++; if (polygons_on_screen_out !== 3'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", polygons_on_screen_out); end
        checks++; if (num_sides_out[0] !== 4'd0) begin failures++; $display("FAIL rmid_sides0 got=%0d exp=0", num_sides_out[0]); end
        checks++; if (vertex_ready_out !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%0d exp=1", vertex_ready_out); end
        checks++; if (swap_out !== 1'b0) begin failures++; $display("FAIL rmid_swap got=%0d exp=0", swap_out); end
        checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL rmid_overflow got=%0d exp=0", overflow_out); end
        send_poly(3, 800, 1'b1, 1'b0);
        pulse_frame();
        checks++; if (polygons_on_screen_out !== 3'd1) begin failures++; $display("FAIL rmid_after_count got=%0d exp=1", polygons_on_screen_out); end
        checks++; if (num_sides_out[0] !== 4'd3) begin failures++; $display("FAIL rmid_after_sides0 got=%0d exp=3", num_sides_out[0]); end
        checks++; if (xs_out[0][0] !== 32'sd800) begin failures++; $display("FAIL rmid_after_x00 got=%0d exp=800", xs_out[0][0]); end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_in          = 1'b1;
        frame_start_in  = 1'b0;
        vertex_valid_in = 1'b0;
        vertex_x_in     = '0;
        vertex_y_in     = '0;
        vertex_last_in  = 1'b0;
        scene_last_in   = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_three_polys();
        test_vertex_overflow();
        test_poly_overflow();
        test_degenerate();
        test_back_to_back_frame();
        test_empty_scene();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scene_bank_loader.md
# scene_bank_loader

Double-buffered polygon scene store that sits between the game/physics logic and the bank of `draw_polygon` instances inside `render`. It accepts a stream of vertices over a valid/ready handshake and builds the next scene in a back bank. On a frame-start pulse it swaps banks, so the draw units always see a complete, frame-stable polygon set. It replaces the hard-wired vertex tables and polygon count currently driven into `render`.

## Interface
- `MAX_NUM_VERTICES`, 8, vertex slots per polygon.
- `MAX_POLYGONS_ON_SCREEN`, 4, polygon slots per bank.
- `clk_in` input 1: single system clock.
- `rst_in` input 1: synchronous, active-high reset.
- `frame_start_in` input 1: one-cycle pulse at the start of vertical blanking; this is the swap opportunity.
- `vertex_valid_in` input 1: a vertex beat is offered.
- `vertex_ready_out` output 1: the loader can accept a beat.
- `vertex_x_in` input 32 signed: world-space x of the vertex.
- `vertex_y_in` input 32 signed: world-space y of the vertex.
- `vertex_last_in` input 1: this beat is the last vertex of its polygon.
- `scene_last_in` input 1: this beat closes the scene. Meaningful only when `vertex_last_in`=1.
- `xs_out` output [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES] x 32 signed: front-bank x coordinates.
- `ys_out` output, same shape as `xs_out`: front-bank y coordinates.
- `num_sides_out` output [MAX_POLYGONS_ON_SCREEN] x $clog2(MAX_NUM_VERTICES+1): vertex count per front-bank slot.
- `polygons_on_screen_out` output $clog2(MAX_POLYGONS_ON_SCREEN+1): number of valid front-bank slots.
- `swap_out` output 1: one-cycle pulse on the cycle the front-bank outputs change.
- `overflow_out` output 1: sticky flag, set when any beat of the current back scene was dropped.

## Operation
- Storage: two banks, each holding the xs/ys arrays, per-slot counts and a polygon count. The `bank_sel` register selects the front bank, and all outputs are driven from the front bank.
- States:
  - LOAD: `vertex_ready_out`=1. A beat is accepted on `vertex_valid_in && vertex_ready_out`. The vertex is written to back[`poly_idx`][`vert_idx`], then `vert_idx` increments.
  - On `vertex_last_in`:
    - If `vert_idx+1` ≥ 3, the slot is committed: its num_sides is set to min(`vert_idx+1`, MAX_NUM_VERTICES), `poly_idx` increments, and `vert_idx` is cleared.
    - If fewer than 3 vertices arrived, the slot is discarded and `poly_idx` is unchanged.
  - If `scene_last_in` is also set, go to READY.
  - READY: `vertex_ready_out`=0. The scene is complete and waits for `frame_start_in`. On `frame_start_in`:
    - toggle `bank_sel`, pulse `swap_out` on the next cycle, and clear the new back bank's polygon count and the indices;
    - clear `overflow_out`;
    - go to LOAD.
- Vertex overflow: beats beyond MAX_NUM_VERTICES within one polygon are accepted but not stored. `vert_idx` saturates and `overflow_out` is set.
- Polygon overflow: once `poly_idx` = MAX_POLYGONS_ON_SCREEN, further beats are accepted and dropped, with `overflow_out` set, until the `scene_last_in` beat. That beat still moves the state to READY.
- Stale data: slots at or above `polygons_on_screen_out` may hold stale coordinates. Consumers must gate on the count.
- Incomplete scene: a `frame_start_in` in LOAD causes no swap, and the front bank keeps showing the previous scene.
- Empty scene: a `scene_last_in` beat that is itself discarded (a polygon under 3 vertices) still completes the scene. Such a scene may hold 0 polygons.

## Timing
- Reset value of every output is 0, except `vertex_ready_out`=1 (LOAD).
  - `bank_sel`=0, both banks' counts are 0 and the indices are 0.
  - Coordinate registers need no reset, but `num_sides_out` is 0.
- Handshake:
  - `vertex_ready_out` is a registered state decode and does not combinationally depend on `vertex_valid_in`.
  - Throughput is one beat per cycle in LOAD.
- Scene-closing beat: the beat carrying `scene_last_in` is accepted in cycle N, the state is READY in N+1, and `vertex_ready_out`=0 from N+1.
- Swap latency: `frame_start_in` is sampled high in READY in cycle N. New `xs_out`/`ys_out`/`num_sides_out`/`polygons_on_screen_out` and `swap_out`=1 appear in N+1, and `vertex_ready_out`=1 in N+1.
- Same-cycle start and last beat: if `frame_start_in` and the scene-closing beat coincide in LOAD, the beat is accepted and no swap occurs. The swap waits for the next `frame_start_in`.
- Reset mid-load: all partial back-bank progress is discarded, and the front count reads 0 in the cycle after `rst_in`.
- Width rules:
  - Coordinates are stored verbatim with no scaling.
  - Counters are sized `$clog2(MAX+1)` so the value MAX is representable.

## Test plan
- Basic scene: reset, then stream a square (100,100)(200,100)(200,200)(100,200) with last+scene_last on beat 4, then pulse `frame_start_in`.
  - Expect `swap_out` one cycle later, `polygons_on_screen_out`=1, `num_sides_out[0]`=4, and `xs_out[0][2]`=200.
- Three polygons with 4, 3 and 5 vertices, then a swap.
  - Expect counts 4/3/5 and `polygons_on_screen_out`=3.
  - Then stream a 1-polygon scene without a frame pulse: the outputs must still show 3 polygons.
- Vertex overflow: send 10 vertices to one polygon.
  - Expect `num_sides_out[0]`=8, `overflow_out`=1, and `vertex_ready_out` held at 1 throughout LOAD.
- Polygon overflow: send 6 triangles with scene_last on the sixth.
  - Expect `polygons_on_screen_out`=4 after the swap and the state reaching READY.
- Degenerate and timing cases:
  - A 2-vertex polygon between two triangles gives `polygons_on_screen_out`=2.
  - A `frame_start_in` coincident with the scene-closing beat gives no `swap_out`; the next pulse swaps.
- Reset asserted mid-stream: the next cycle has all outputs at 0 and `vertex_ready_out`=1.
